fifo_rd_fwft_stage: RTL and testbench
=====================================

// Module: fifo_rd_fwft_stage
// PURPOSE
//  Read-domain output stage of the async FIFO. Sits downstream of the read pointer handler and the dual-port RAM.
//  Converts the FIFO's "pulse r_en, data next cycle" read port into a first-word-fall-through valid/ready stream.
//  Holds up to 2 words so back-to-back reads sustain 1 word/rclk under continuous m_ready.
//  Drives r_en into the pointer handler and counts delivered words.
// PARAMETERS
//  DATA_WIDTH  8   width of RAM read data and output stream
//  CNT_WIDTH   16  width of delivered-word counter (saturating)
// PORTS
//  rclk        in   1           read clock; all logic on posedge
//  rrst_n      in   1           reset, asynchronous, active-low
//  fifo_empty  in   1           registered empty flag from read pointer handler
//  r_en        out  1           read request to pointer handler/RAM
//  fifo_rdata  in   DATA_WIDTH  RAM read data, valid the rclk after r_en was high
//  m_valid     out  1           output word available
//  m_ready     in   1           consumer accepts word when m_valid & m_ready
//  m_data      out  DATA_WIDTH  output word (head of buffer)
//  rd_cnt      out  CNT_WIDTH   words delivered since reset, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rrst_n low):
//   - count=0, inflight=0, m_valid=0, m_data=0, rd_cnt=0, buffer entries=0.
//   - r_en=0: combinational, forced low while rrst_n low.
//  Definitions:
//   - pop      = m_valid & m_ready
//   - inflight = registered r_en: a read was issued last cycle
//   - push     = inflight: capture fifo_rdata at this edge
//  Issue rule, combinational:
//   - r_en = rrst_n & ~fifo_empty & (count + inflight - pop <= 1)
//   - r_en never depends on m_data; pop lookahead is required for full throughput.
//  Invariant: count + inflight <= 2 every cycle; assert overflow never occurs.
//  Buffer: 2 entries (head/tail), states by count:
//   - EMPTY(0): push->ONE; pop impossible.
//   - ONE(1): push&~pop->TWO; ~push&pop->EMPTY; push&pop->ONE, new word becomes head.
//   - TWO(2): pop&~push->ONE; push&pop->TWO; push without pop is illegal (assert).
//  Outputs:
//   - m_valid = (count != 0); m_data = head entry, both registered.
//   - m_data is stable while m_valid & ~m_ready.
//  Latency:
//   - fifo_empty falls in cycle T -> r_en high in T -> data captured at end of T+1 -> m_valid high in T+2.
//  Ordering: words leave in exactly the order r_en was issued; no drop, no duplicate.
//  rd_cnt: +1 on each pop; holds at 2^CNT_WIDTH-1 once reached.
//  Boundaries:
//   - fifo_empty rises while a read is in flight: the in-flight word is still captured.
//   - r_en goes low the same cycle empty is seen.
//   - m_ready held low: at most 2 words buffered; r_en stays 0 until a pop.
//   - Reset mid-transfer: buffered and in-flight words are discarded, all state returns to reset values.
//  Reset release: no r_en until fifo_empty is observed low.
// STRUCTURE
//  Shared package async_fifo_pkg:
//   - DATA_WIDTH default.
//   - typedef enum logic[1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} rd_buf_state_t
//   - typedef logic [DATA_WIDTH-1:0] fifo_word_t
//  Sub-module fifo_skid_buf2: 2-entry push/pop register buffer with count.
//  Top level holds the issue logic, inflight flop and rd_cnt.
// TESTING
//  1. Reset with fifo_empty=1 -> r_en=0, m_valid=0, rd_cnt=0 for 10 cycles.
//  2. Single word 0xA5: fifo_empty low 1 cycle then high, m_ready=1 -> exactly one r_en pulse;
//     m_valid high 2 cycles after empty fell with m_data=0xA5; rd_cnt=1.
//  3. Burst 0x01..0x10, fifo_empty=0, m_ready=1 -> after 2-cycle fill, 16 consecutive beats, in order, no gaps.
//  4. Backpressure: empty=0, m_ready=0 for 8 cycles -> exactly 2 r_en pulses, m_data=0x01 stable;
//     release m_ready -> 0x01, 0x02, 0x03... in order.
//  5. Random m_ready (50%) with random fifo_empty over 1000 words -> scoreboard matches order;
//     count+inflight<=2 always holds; rd_cnt=1000.
//  6. rrst_n asserted with 2 words buffered and 1 in flight -> m_valid=0 and r_en=0 immediately;
//     after release no stale word appears; CNT_WIDTH=4 run of 20 pops -> rd_cnt=15.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
//   DEF_DATA_WIDTH  : default data width of RAM words and the output stream
//   DEF_CNT_WIDTH   : default width of the delivered-word counter
//   rd_buf_state_t  : occupancy states of the 2-entry output buffer
//   fifo_word_t     : one FIFO word at the default width
//   buf_count()     : maps a buffer state onto its word count
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } rd_buf_state_t;

    typedef logic [DEF_DATA_WIDTH-1:0] fifo_word_t;

    function automatic logic [1:0] buf_count(input rd_buf_state_t s);
        logic [1:0] c;
        c = 2'd0;
        case (s)
            BUF_ONE: c = 2'd1;
            BUF_TWO: c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry push/pop register buffer feeding the read-side output stream.
// The head entry is what the consumer sees; the tail entry only fills when a
// word arrives while the head is still waiting to be accepted.
//   rclk     in   read clock
//   rrst_n   in   asynchronous active-low reset
//   push_i   in   capture data_i at this edge
//   pop_i    in   consumer takes the head at this edge
//   data_i   in   incoming word
//   valid_o  out  head entry holds a word
//   data_o   out  head entry
//   count_o  out  number of words held (0..2)
//
// state     | meaning
// BUF_EMPTY | no word held, head stale
// BUF_ONE   | head valid, tail unused
// BUF_TWO   | head and tail valid, tail is next after head
module fifo_skid_buf2
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    rd_buf_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    state_d = BUF_ONE;
                    head_d  = data_i;
                end
            end
            BUF_ONE: begin
                case ({push_i, pop_i})
                    2'b10: begin
                        state_d = BUF_TWO;
                        tail_d  = data_i;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    // head leaves and the arriving word takes its place
                    2'b11: head_d = data_i;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        valid_o = (state_q != BUF_EMPTY);
        data_o  = head_q;
        count_o = buf_count(state_q);
    end

    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !((state_q == BUF_TWO) && push_i && !pop_i));

endmodule

// File: rtl/fifo_rd_fwft_stage.sv
// Read-domain output stage of the async FIFO. Turns the RAM's
// "pulse r_en, data next cycle" port into a first-word-fall-through
// valid/ready stream, buffering up to two words so a continuously ready
// consumer gets one word per rclk.
//   rclk        in   read clock
//   rrst_n      in   asynchronous active-low reset
//   fifo_empty  in   registered empty flag from the read pointer handler
//   r_en        out  read request to pointer handler / RAM
//   fifo_rdata  in   RAM data, valid the cycle after r_en
//   m_valid     out  output word available
//   m_ready     in   consumer accepts when m_valid & m_ready
//   m_data      out  head word
//   rd_cnt      out  words delivered since reset, saturating
module fifo_rd_fwft_stage
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]           count;
    logic                 pop;
    logic [2:0]           occ_after_pop;

    assign pop = m_valid & m_ready;

    // Occupancy once this edge's pop is taken; the in-flight word is already
    // committed. pop implies count >= 1, so this cannot wrap.
    assign occ_after_pop = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

    assign r_en = rrst_n & ~fifo_empty & (occ_after_pop <= 3'd1);

    assign inflight_d = r_en;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (pop && (rd_cnt_q != {CNT_WIDTH{1'b1}})) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;

    fifo_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  (fifo_rdata),
        .valid_o (m_valid),
        .data_o  (m_data),
        .count_o (count)
    );

    a_occ_limit: assert property (@(posedge rclk) disable iff (!rrst_n)
        (({1'b0, count} + {2'b00, inflight_q}) <= 3'd2));

endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
module tb_fifo_rd_fwft_stage;

    logic       rclk;
    logic       rrst_n;
    logic       fifo_empty;
    logic       r_en;
    logic [7:0] fifo_rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [15:0] rd_cnt;

    logic       rrst2_n;
    logic       fifo_empty2;
    logic       r_en2;
    logic [7:0] fifo_rdata2;
    logic       m_valid2;
    logic       m_ready2;
    logic [7:0] m_data2;
    logic [3:0] rd_cnt2;

    int n_chk = 0;
    int n_bad = 0;

    // source FIFO model
    logic [7:0] mem [0:4095];
    int rptr   = 0;
    int wlimit = 0;
    logic hold_empty = 1'b1;

    // black-box occupancy model and scoreboard
    logic mon_en = 1'b0;
    int buf_m  = 0;
    int infl_m = 0;
    int npop   = 0;
    int nren   = 0;
    int sb_idx = 0;
    int npop2  = 0;

    fifo_rd_fwft_stage #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .fifo_empty (fifo_empty),
        .r_en       (r_en),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rd_cnt     (rd_cnt)
    );

    fifo_rd_fwft_stage #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
        .rclk       (rclk),
        .rrst_n     (rrst2_n),
        .fifo_empty (fifo_empty2),
        .r_en       (r_en2),
        .fifo_rdata (fifo_rdata2),
        .m_valid    (m_valid2),
        .m_ready    (m_ready2),
        .m_data     (m_data2),
        .rd_cnt     (rd_cnt2)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    assign fifo_empty = hold_empty || (rptr >= wlimit);

    always @(posedge rclk) begin
        if (r_en) begin
            fifo_rdata <= mem[rptr[11:0]];
            rptr       <= rptr + 1;
        end
    end

    always @(posedge rclk) begin
        fifo_rdata2 <= 8'($urandom_range(0, 255));
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    always @(negedge rclk) begin
        int pop;
        int exp_ren;
        if (mon_en && rrst_n) begin
            pop = (m_valid && m_ready) ? 1 : 0;
            chk("m_valid", int'(m_valid), (buf_m != 0) ? 1 : 0);
            exp_ren = (!fifo_empty && (buf_m + infl_m - pop <= 1)) ? 1 : 0;
            chk("r_en", int'(r_en), exp_ren);
            chk("rd_cnt", int'(rd_cnt), npop);
            if (m_valid) begin
                chk("m_data", int'(m_data), int'(mem[sb_idx[11:0]]));
            end
            if (pop != 0) begin
                sb_idx++;
                npop++;
            end
            buf_m  = buf_m + infl_m - pop;
            infl_m = r_en ? 1 : 0;
            if (r_en) nren++;
        end
    end

    always @(negedge rclk) begin
        if (rrst2_n) begin
            chk("sat_cnt", int'(rd_cnt2), (npop2 > 15) ? 15 : npop2);
            if (m_valid2 && m_ready2) npop2++;
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rrst_n = 1'b0;
        repeat (2) tick();
        buf_m  = 0;
        infl_m = 0;
        npop   = 0;
        sb_idx = rptr;
        rrst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ren;
        int base_pop;
        int cyc;
        int rel_ptr;

        rrst_n      = 1'b0;
        m_ready     = 1'b0;
        hold_empty  = 1'b1;
        rrst2_n     = 1'b0;
        fifo_empty2 = 1'b0;
        m_ready2    = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);

        // 1: reset state, then idle with empty high
        repeat (3) begin
            @(negedge rclk);
            chk("rst_r_en", int'(r_en), 0);
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_m_data", int'(m_data), 0);
            chk("rst_rd_cnt", int'(rd_cnt), 0);
        end
        tick();
        rrst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            chk("idle_r_en", int'(r_en), 0);
            chk("idle_m_valid", int'(m_valid), 0);
            chk("idle_rd_cnt", int'(rd_cnt), 0);
        end

        // 2: single word 0xA5, latency
        tick();
        mem[rptr[11:0]] = 8'hA5;
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        wlimit     = rptr + 1;
        base_ren   = nren;
        @(negedge rclk);
        chk("single_ren_T", int'(r_en), 1);
        chk("single_v_T", int'(m_valid), 0);
        @(negedge rclk);
        chk("single_ren_T1", int'(r_en), 0);
        chk("single_v_T1", int'(m_valid), 0);
        @(negedge rclk);
        chk("single_v_T2", int'(m_valid), 1);
        chk("single_d_T2", int'(m_data), 8'hA5);
        @(negedge rclk);
        chk("single_v_T3", int'(m_valid), 0);
        chk("single_cnt", int'(rd_cnt), 1);
        chk("single_pulses", nren - base_ren, 1);

        // 3: burst 0x01..0x10 with m_ready high
        tick();
        for (int k = 0; k < 16; k++) mem[(rptr + k) & 4095] = 8'(k + 1);
        wlimit = rptr + 16;
        for (int i = 0; i < 18; i++) begin
            @(negedge rclk);
            chk("burst_v", int'(m_valid), (i >= 2) ? 1 : 0);
            if (i >= 2) chk("burst_d", int'(m_data), i - 1);
        end
        @(negedge rclk);
        chk("burst_end_v", int'(m_valid), 0);
        chk("burst_cnt", int'(rd_cnt), 17);

        // 4: backpressure fills exactly two words, then drains in order
        tick();
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) mem[(rptr + k) & 4095] = 8'(k + 1);
        wlimit   = rptr + 6;
        base_ren = nren;
        base_pop = npop;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            if (i >= 2) chk("bp_hold_d", int'(m_data), 1);
        end
        chk("bp_pulses", nren - base_ren, 2);
        tick();
        m_ready = 1'b1;
        cyc = 0;
        while ((npop - base_pop) < 6 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("bp_drained", npop - base_pop, 6);

        // 6a: reset mid-transfer with two words held
        tick();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) mem[(rptr + k) & 4095] = 8'(8'h80 + k);
        wlimit = rptr + 5;
        repeat (6) @(negedge rclk);
        tick();
        #2;
        mon_en = 1'b0;
        rrst_n = 1'b0;
        #1;
        chk("mid_rst_v", int'(m_valid), 0);
        chk("mid_rst_ren", int'(r_en), 0);
        chk("mid_rst_cnt", int'(rd_cnt), 0);
        chk("mid_rst_d", int'(m_data), 0);
        hold_empty = 1'b1;
        repeat (2) tick();
        buf_m   = 0;
        infl_m  = 0;
        npop    = 0;
        sb_idx  = rptr;
        rel_ptr = rptr;
        rrst_n  = 1'b1;
        mon_en  = 1'b1;
        repeat (3) begin
            @(negedge rclk);
            chk("post_rst_ren", int'(r_en), 0);
            chk("post_rst_v", int'(m_valid), 0);
        end
        tick();
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        cyc = 0;
        while (npop < (wlimit - rel_ptr) && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("post_rst_pops", npop, 3);

        // 5: random m_ready / fifo_empty over 1000 words
        tick();
        m_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 1000; k++) mem[(rptr + k) & 4095] = 8'($urandom_range(0, 255));
        wlimit = rptr + 1000;
        cyc = 0;
        while (npop < 1000 && cyc < 20000) begin
            tick();
            m_ready    = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            cyc++;
        end
        tick();
        m_ready    = 1'b0;
        hold_empty = 1'b0;
        @(negedge rclk);
        chk("rand_pops", npop, 1000);
        chk("rand_rd_cnt", int'(rd_cnt), 1000);

        // 6b: saturating counter on the 4-bit instance
        tick();
        rrst2_n = 1'b1;
        cyc = 0;
        while (npop2 < 20 && cyc < 100) begin
            tick();
            cyc++;
        end
        @(negedge rclk);
        chk("sat_pops", (npop2 >= 20) ? 1 : 0, 1);
        chk("sat_final", int'(rd_cnt2), 15);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
